frame_word_packer: RTL and testbench

FRAME_WORD_PACKER -- requirements
Module: frame_word_packer

---
 rtl/frame_word_packer.sv | 166 ++++++++++++++++
 tb/tb_frame_word_packer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_word_packer.sv
// frame_word_packer: collects serial sdi bits into 4-bit words for each frame
// started by a rising edge of frame_clk, buffers them in a 4-entry FIFO and
// presents them one per cycle as registered req/data strobes.
// Optional feature macro: PARITY_CHK_EN -- each serial word carries 4 data bits
// followed by an even-parity bit; a bad word raises par_err alongside its req.
//
// Output handshake: req/data is a push-only strobe interface with no
// back-pressure. data is meaningful only in a cycle where req=1 and holds its
// last value otherwise; every req=1 cycle delivers exactly one word.
module frame_word_packer #(
  parameter int WORDS_PER_FRAME = 4
) (
  input  logic       clk_2,
  input  logic       rst,
  input  logic       frame_clk,
  input  logic       sdi,
  input  logic       sdi_vld,
  input  logic       test_hold,   // white-box hook: suppresses pops so the FIFO can fill
  output logic       req,
  output logic [3:0] data,
  output logic       frame_done,
  output logic       frame_err,
  output logic       ovf,
  output logic       par_err,
  output logic [1:0] fsm_state    // debug view of the control FSM (IDLE=0, COLLECT=1, DRAIN=2)
);

`ifdef PARITY_CHK_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif
  localparam int WCW = $clog2(WORDS_PER_FRAME + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state, next_state;
  logic [2:0]     sync;          // [0]=sync1, [1]=sync2, [2]=history flop
  logic           fs;
  logic           collecting, drain_exit, restart;
  logic [2:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [EW-2:0]  sr;            // bits preceding the final bit of the current word
  logic           word_done, last_word;
  logic [EW-1:0]  word, head;
  logic [EW-1:0]  mem [4];
  logic [2:0]     wptr, rptr;
  logic           fifo_empty, fifo_full, pop, push;

  assign fsm_state = state;

  // Bring frame_clk into the clk_2 domain and keep one history bit for edge detect.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], frame_clk};
  end

  assign fs = sync[1] & ~sync[2];

  // FSM state register.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state: a frame start always (re)enters COLLECT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fs) next_state = COLLECT;
      COLLECT: begin
        if (fs)                          next_state = COLLECT;
        else if (word_done && last_word) next_state = DRAIN;
      end
      DRAIN: begin
        if (fs)              next_state = COLLECT;
        else if (fifo_empty) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: decoded controls for the datapath and status pulses.
  always_comb begin
    collecting = (state == COLLECT);
    drain_exit = (state == DRAIN) && fifo_empty && !fs;
    restart    = fs && (state != IDLE);
  end

  assign word_done = collecting && sdi_vld && (bit_cnt == 3'(EW - 1));
  assign last_word = (word_cnt == WCW'(WORDS_PER_FRAME - 1));
  assign word      = {sr, sdi};

  // Bit/word counters and shift register; a frame start discards any partial word.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      sr       <= '0;
    end else if (fs) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      sr       <= '0;
    end else if (collecting && sdi_vld) begin
      sr <= {sr[EW-3:0], sdi};
      if (bit_cnt == 3'(EW - 1)) begin
        bit_cnt  <= '0;
        word_cnt <= word_cnt + WCW'(1);
      end else begin
        bit_cnt  <= bit_cnt + 3'd1;
      end
    end
  end

  // FIFO flags from the wrap-bit pointer compare. When the FIFO is empty a
  // completing word is popped straight through so req follows the last bit by one cycle.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[1:0] == rptr[1:0]) && (wptr[2] != rptr[2]);
  assign pop        = !test_hold && (!fifo_empty || word_done);
  assign push       = word_done && (!fifo_full || pop);
  assign head       = fifo_empty ? word : mem[rptr[1:0]];

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_2) begin
    if (push) mem[wptr[1:0]] <= word;
  end

  // FIFO pointers.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 3'd1;
      if (pop)  rptr <= rptr + 3'd1;
    end
  end

  // Registered output strobe, held data, status pulses and sticky overflow.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      req        <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      req        <= pop;
      if (pop) data <= head[EW-1 -: 4];
      frame_done <= drain_exit;
      frame_err  <= restart;
      if (word_done && !push) ovf <= 1'b1;
    end
  end

`ifdef PARITY_CHK_EN
  // Even parity over data plus parity bit; flagged in the same cycle as the word's req.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= pop && (^head);
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_word_packer.sv
// Self-checking bench for frame_word_packer: reset, table-driven frames,
// directed corner sequences and a randomized run against a queue-based model.
module tb_frame_word_packer;

`ifdef PARITY_CHK_EN
  localparam int BPW = 5;
  localparam bit PAR = 1'b1;
`else
  localparam int BPW = 4;
  localparam bit PAR = 1'b0;
`endif
  localparam int WPF = 4;

  logic       clk_2 = 1'b0;
  logic       rst, frame_clk, sdi, sdi_vld, test_hold;
  logic       req, frame_done, frame_err, ovf, par_err;
  logic [3:0] data;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  frame_word_packer #(.WORDS_PER_FRAME(WPF)) dut (
    .clk_2      (clk_2),
    .rst        (rst),
    .frame_clk  (frame_clk),
    .sdi        (sdi),
    .sdi_vld    (sdi_vld),
    .test_hold  (test_hold),
    .req        (req),
    .data       (data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .ovf        (ovf),
    .par_err    (par_err),
    .fsm_state  (fsm_state)
  );

  // Clock and reset block.
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: frame_clk rise; fs takes effect on the third edge.
  task automatic start_frame(input logic exp_err);
    frame_clk = 1'b1;
    tick();
    tick();
    frame_clk = 1'b0;
    tick();
    check("frame_err", frame_err, exp_err);
    tick();
    check("frame_err_one_cycle", frame_err, 0);
  endtask

  // Driver: one serial word back-to-back, MSB first, parity bit last when enabled.
  task automatic send_word(input logic [3:0] nib, input logic pbit, input logic exp_req,
                           input logic [3:0] exp_data, input logic exp_perr);
    logic [4:0] w5;
    w5 = {nib, pbit};
    for (int b = 0; b < BPW; b++) begin
      sdi     = w5[4-b];
      sdi_vld = 1'b1;
      tick();
      if (b == BPW - 1) begin
        check("word_req", req, exp_req);
        if (exp_req) begin
          check("word_data", data, exp_data);
          check("word_par_err", par_err, exp_perr);
        end
      end else begin
        check("bit_req_low", req, 0);
      end
    end
    sdi_vld = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] bits;
    logic [3:0]  gap;
    logic [15:0] exp_words;
  } vec_t;

  task automatic run_frame(input vec_t v);
    logic [3:0] nib, exp_nib;
    for (int w = 0; w < WPF; w++) begin
      nib     = v.bits[15-4*w -: 4];
      exp_nib = v.exp_words[15-4*w -: 4];
      send_word(nib, ^nib, 1'b1, exp_nib, 1'b0);
      if (w < WPF - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          tick();
          check("gap_req_low", req, 0);
          check("gap_data_hold", data, exp_nib);
          check("gap_no_done", frame_done, 0);
        end
      end
    end
    tick();
    check("frame_done", frame_done, 1);
    check("done_req_low", req, 0);
    tick();
    check("done_one_cycle", frame_done, 0);
    check("back_to_idle", fsm_state, 0);
  endtask

  // Scoreboard / reference model: words queue in exp_q, popped when the
  // output side is not held; a frame is tracked as collecting or draining.
  logic [4:0] exp_q[$];
  logic       bit_q[$];
  bit         m_collect, m_drain, m_ovf;
  int         m_words;
  logic [3:0] m_data;
  logic       h1, h2, h3;

  task automatic model_reset();
    exp_q.delete();
    bit_q.delete();
    m_collect = 0; m_drain = 0; m_ovf = 0; m_words = 0;
    m_data = '0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_step();
    logic fs_m, nw, e_req, e_done, e_err, e_perr;
    logic [4:0] w5, ent;
    fs_m = h2 & ~h3;
    e_req = 0; e_done = 0; e_err = 0; e_perr = 0; nw = 0; w5 = '0;
    if (m_drain && exp_q.size() == 0 && !fs_m) begin
      e_done  = 1;
      m_drain = 0;
    end
    if (m_collect && sdi_vld) begin
      bit_q.push_back(sdi);
      if (bit_q.size() == BPW) begin
        for (int i = 0; i < BPW; i++) w5[4-i] = bit_q[i];
        nw = 1;
        bit_q.delete();
        m_words++;
      end
    end
    if (fs_m) begin
      e_err     = m_collect | m_drain;
      m_collect = 1;
      m_drain   = 0;
      bit_q.delete();
      m_words   = 0;
    end else if (nw && m_words == WPF) begin
      m_collect = 0;
      m_drain   = 1;
    end
    if (nw) begin
      if (exp_q.size() < 4 || !test_hold) exp_q.push_back(w5);
      else m_ovf = 1;
    end
    if (!test_hold && exp_q.size() > 0) begin
      ent    = exp_q.pop_front();
      e_req  = 1;
      m_data = ent[4:1];
      e_perr = PAR ? (^ent) : 1'b0;
    end
    h3 = h2; h2 = h1; h1 = frame_clk;
    check("rnd_req", req, e_req);
    check("rnd_data", data, m_data);
    check("rnd_frame_done", frame_done, e_done);
    check("rnd_frame_err", frame_err, e_err);
    check("rnd_ovf", ovf, m_ovf);
    check("rnd_par_err", par_err, e_perr);
  endtask

  vec_t vecs[5];

  initial begin
    int ep_left, fc_left, hold_left;
    vecs[0] = '{16'b1010_0011_1111_0000, 4'd0, 16'hA3F0};
    vecs[1] = '{16'b0101_1100_1000_0001, 4'd1, 16'h5C81};
    vecs[2] = '{16'b1111_1111_1111_1111, 4'd2, 16'hFFFF};
    vecs[3] = '{16'b0000_0000_0000_0000, 4'd0, 16'h0000};
    vecs[4] = '{16'b0001_1110_0110_1001, 4'd3, 16'h1E69};

    rst = 1'b1; frame_clk = 1'b0; sdi = 1'b0; sdi_vld = 1'b0; test_hold = 1'b0;
    repeat (3) tick();
    check("rst_req", req, 0);
    check("rst_data", data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_par_err", par_err, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    tick();

    // Serial data before any frame start is ignored.
    for (int i = 0; i < 12; i++) begin
      sdi = 1'($urandom_range(0, 1));
      sdi_vld = 1'b1;
      tick();
      check("pre_frame_req", req, 0);
      check("pre_frame_state", fsm_state, 0);
    end
    sdi_vld = 1'b0;

    // Table-driven complete frames.
    for (int t = 0; t < 5; t++) begin
      start_frame(1'b0);
      run_frame(vecs[t]);
    end

    // Restart after one word plus two bits.
    start_frame(1'b0);
    send_word(4'hC, 1'b0, 1'b1, 4'hC, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sdi = 1'b1; sdi_vld = 1'b1;
      tick();
      check("partial_req_low", req, 0);
    end
    sdi_vld = 1'b0;
    start_frame(1'b1);
    run_frame('{16'b0110_1001_0111_0010, 4'd0, 16'h6972});

    // Reset mid-frame after two words plus one bit.
    start_frame(1'b0);
    send_word(4'h9, 1'b0, 1'b1, 4'h9, 1'b0);
    send_word(4'h6, 1'b0, 1'b1, 4'h6, 1'b0);
    sdi = 1'b1; sdi_vld = 1'b1;
    tick();
    check("mid_req_low", req, 0);
    sdi_vld = 1'b0;
    rst = 1'b1;
    #2;
    check("async_rst_data", data, 0);
    check("async_rst_state", fsm_state, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sdi = 1'($urandom_range(0, 1)); sdi_vld = 1'b1;
      tick();
      check("post_rst_req", req, 0);
      check("post_rst_state", fsm_state, 0);
    end
    sdi_vld = 1'b0;
    start_frame(1'b0);
    run_frame(vecs[0]);

    // Fill the FIFO with pops held, overflow it, then drain.
    test_hold = 1'b1;
    start_frame(1'b0);
    send_word(4'hA, 1'b0, 1'b0, 4'h0, 1'b0);
    send_word(4'hB, 1'b1, 1'b0, 4'h0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0, 4'h0, 1'b0);
    send_word(4'hD, 1'b1, 1'b0, 4'h0, 1'b0);
    check("full_no_ovf_yet", ovf, 0);
    tick();
    check("held_no_done", frame_done, 0);
    start_frame(1'b1);
    send_word(4'hE, 1'b1, 1'b0, 4'h0, 1'b0);
    check("ovf_set", ovf, 1);
    test_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_req", req, 1);
      check("drain_data", data, 4'hA + 4'(i));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_end_req", req, 0);
      check("ovf_sticky", ovf, 1);
    end
    rst = 1'b1;
    #2;
    check("ovf_clear_on_rst", ovf, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef PARITY_CHK_EN
    // Parity check: second word has odd parity.
    start_frame(1'b0);
    send_word(4'h5, 1'b0, 1'b1, 4'h5, 1'b0);
    send_word(4'h7, 1'b0, 1'b1, 4'h7, 1'b1);
    send_word(4'h3, 1'b0, 1'b1, 4'h3, 1'b0);
    send_word(4'h8, 1'b1, 1'b1, 4'h8, 1'b0);
    tick();
    check("par_frame_done", frame_done, 1);
    check("par_err_one_cycle", par_err, 0);
    tick();
`endif

    // Randomized run against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    ep_left = 0; fc_left = 0; hold_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ep_left == 0) begin
        ep_left = $urandom_range(6, 50);
        fc_left = 2;
      end
      frame_clk = (fc_left > 0);
      if (fc_left > 0) fc_left--;
      ep_left--;
      if (hold_left > 0) begin
        test_hold = 1'b1;
        hold_left--;
      end else begin
        test_hold = 1'b0;
        if ($urandom_range(0, 39) == 0) hold_left = $urandom_range(3, 25);
      end
      sdi     = 1'($urandom_range(0, 1));
      sdi_vld = ($urandom_range(0, 3) != 0);
      tick();
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
